// File: rtl/wb_cebrg.sv
// -----------------------------------------------------------------------------
// wb_cebrg - Wishbone rate bridge, clock-enable qualified slow side to a
// full-rate classic Wishbone slave, single clock.
//
// A slow-side request (sampled only when ce_i is high) is captured into the
// wbm_* registers and issued as exactly one full-rate classic cycle. The
// full-rate response (ack, err or timeout) is parked until the next slow edge
// and then presented on wbs_ack_o / wbs_err_o for exactly one slow cycle.
//
// Ports
//   sys_clk, sys_rst      : clock, synchronous active-high reset
//   ce_i                  : one-cycle strobe marking each slow-domain edge
//   wbs_*_i / wbs_*_o     : slow-side Wishbone slave port (request in, response out)
//   wbm_*_o / wbm_*_i     : full-rate Wishbone master port (cti fixed to 3'b111)
// -----------------------------------------------------------------------------
module wb_cebrg #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          ce_i,
  // slow side
  input  logic [AW-1:0] wbs_adr_i,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic [SW-1:0] wbs_sel_i,
  input  logic          wbs_we_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  output logic [DW-1:0] wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_err_o,
  // full-rate side
  output logic [AW-1:0] wbm_adr_o,
  output logic [DW-1:0] wbm_dat_o,
  output logic [SW-1:0] wbm_sel_o,
  output logic          wbm_we_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic [2:0]    wbm_cti_o,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i
);

  // Counter must hold the value TIMEOUT; keep at least one bit when disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            we_q, we_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic            err_q, err_d;
  logic            sack_q, sack_d;
  logic            serr_q, serr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    sack_d  = sack_q;
    serr_d  = serr_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (ce_i && wbs_cyc_i && wbs_stb_i) begin
          adr_d   = wbs_adr_i;
          wdat_d  = wbs_dat_i;
          sel_d   = wbs_sel_i;
          we_d    = wbs_we_i;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // ack has priority over err when both arrive in the same cycle
        if (wbm_ack_i) begin
          if (!we_q) begin
            rdat_d = wbm_dat_i;
          end
          err_d   = 1'b0;
          state_d = S_HOLD;
        end else if (wbm_err_i) begin
          err_d   = 1'b1;
          state_d = S_HOLD;
        end else if (TO_EN && (cnt_q == TO_VAL)) begin
          err_d   = 1'b1;
          state_d = S_HOLD;
        end else if (cnt_q != {CW{1'b1}}) begin
          // saturating: never wraps back to zero
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HOLD: begin
        // The response is resolved on the next slow edge; a dropped cyc
        // means the slow master abandoned the cycle, so no ack is given.
        if (ce_i) begin
          if (wbs_cyc_i) begin
            sack_d  = ~err_q;
            serr_d  = err_q;
            state_d = S_ACK;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_ACK: begin
        // The slow edge that retires the ack must not capture a new request.
        if (ce_i) begin
          sack_d  = 1'b0;
          serr_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      sack_q  <= 1'b0;
      serr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      sack_q  <= sack_d;
      serr_q  <= serr_d;
      cnt_q   <= cnt_d;
    end
  end

  // cyc/stb are a decode of the registered state, so reset drops them
  // on the very next edge.
  assign wbm_cyc_o = (state_q == S_REQ);
  assign wbm_stb_o = (state_q == S_REQ);
  assign wbm_cti_o = 3'b111;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = we_q;
  assign wbs_dat_o = rdat_q;
  assign wbs_ack_o = sack_q;
  assign wbs_err_o = serr_q;

endmodule

// File: tb/tb_wb_cebrg.sv
// Bench for wb_cebrg: 32-bit instance with ce every 4 cycles and TIMEOUT=8,
// plus a 64-bit instance with ce tied high. Expected requests/responses are
// queued by the stimulus and consumed by independent monitors.
module tb_wb_cebrg;

  localparam int TO = 8;
  localparam int M_ACK = 0, M_ERR = 1, M_SILENT = 2;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          len;   // expected stb cycles, 0 = do not check
  } req_t;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          len;
  } rsp_t;

  typedef struct {
    logic [63:0] dat;
    int          len;
  } rsp64_t;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic ce_i;
  int   ce_cnt = 0;
  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- 32-bit instance ----------------
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  wb_cebrg #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ce_i(ce_i),
    .wbs_adr_i(s_adr), .wbs_dat_i(s_dat), .wbs_sel_i(s_sel), .wbs_we_i(s_we),
    .wbs_cyc_i(s_cyc), .wbs_stb_i(s_stb),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  // ---------------- 64-bit instance, ce tied high ----------------
  logic [31:0] h_adr;
  logic [63:0] h_dat;
  logic [7:0]  h_sel;
  logic        h_we, h_cyc, h_stb;
  logic [63:0] h_wbs_dat_o;
  logic        h_wbs_ack_o, h_wbs_err_o;
  logic [31:0] h_wbm_adr_o;
  logic [63:0] h_wbm_dat_o;
  logic [7:0]  h_wbm_sel_o;
  logic        h_wbm_we_o, h_wbm_cyc_o, h_wbm_stb_o;
  logic [2:0]  h_wbm_cti_o;
  logic [63:0] h_wbm_dat_i;
  logic        h_wbm_ack_i, h_wbm_err_i;

  wb_cebrg #(.AW(32), .DW(64)) dut64 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ce_i(1'b1),
    .wbs_adr_i(h_adr), .wbs_dat_i(h_dat), .wbs_sel_i(h_sel), .wbs_we_i(h_we),
    .wbs_cyc_i(h_cyc), .wbs_stb_i(h_stb),
    .wbs_dat_o(h_wbs_dat_o), .wbs_ack_o(h_wbs_ack_o), .wbs_err_o(h_wbs_err_o),
    .wbm_adr_o(h_wbm_adr_o), .wbm_dat_o(h_wbm_dat_o), .wbm_sel_o(h_wbm_sel_o),
    .wbm_we_o(h_wbm_we_o), .wbm_cyc_o(h_wbm_cyc_o), .wbm_stb_o(h_wbm_stb_o),
    .wbm_cti_o(h_wbm_cti_o),
    .wbm_dat_i(h_wbm_dat_i), .wbm_ack_i(h_wbm_ack_i), .wbm_err_i(h_wbm_err_i)
  );

  // ---------------- scoreboards ----------------
  req_t   exp_req[$];
  rsp_t   exp_rsp[$];
  rsp64_t exp_rsp64[$];
  logic [31:0] exp_adr64[$];

  // slave behaviour for the 32-bit instance
  int          slv_waits = 0;
  int          slv_mode  = M_ACK;
  logic [31:0] slv_data  = '0;
  logic [63:0] slv_data64 = '0;

  // ce: one-cycle pulse every 4 sys_clk cycles, changed just after posedge
  initial begin
    ce_i = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      ce_cnt = (ce_cnt + 1) % 4;
      ce_i = (ce_cnt == 0);
    end
  end

  // full-rate slave (32-bit)
  initial begin
    int stb_cnt;
    stb_cnt = 0;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
    forever begin
      @(negedge sys_clk);
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      if (wbm_cyc_o && wbm_stb_o) begin
        if (stb_cnt == slv_waits) begin
          if (slv_mode == M_ACK) begin
            wbm_ack_i = 1'b1; wbm_dat_i = slv_data;
          end else if (slv_mode == M_ERR) begin
            wbm_err_i = 1'b1; wbm_dat_i = 32'hBAD0BAD0;
          end
        end
        stb_cnt++;
      end else begin
        stb_cnt = 0;
      end
    end
  end

  // full-rate slave (64-bit): zero wait states
  initial begin
    h_wbm_ack_i = 1'b0; h_wbm_err_i = 1'b0; h_wbm_dat_i = '0;
    forever begin
      @(negedge sys_clk);
      h_wbm_ack_i = h_wbm_cyc_o && h_wbm_stb_o;
      h_wbm_dat_i = slv_data64;
    end
  end

  // monitor: full-rate requests (32-bit)
  initial begin
    bit   act;
    int   len;
    req_t cur;
    act = 0; len = 0;
    forever begin
      @(negedge sys_clk);
      if (wbm_stb_o && !act) begin
        act = 1; len = 1;
        chk("req_cyc", wbm_cyc_o, 1'b1);
        chk("req_cti", wbm_cti_o, 3'b111);
        if (exp_req.size() == 0) begin
          chk("req_unexpected", 1'b1, 1'b0);
          cur.len = 0;
        end else begin
          cur = exp_req.pop_front();
          $display("req: adr=%h dat=%h sel=%h we=%0b", wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o);
          chk("req_adr", wbm_adr_o, cur.adr);
          chk("req_sel", wbm_sel_o, cur.sel);
          chk("req_we", wbm_we_o, cur.we);
          if (cur.we) chk("req_dat", wbm_dat_o, cur.dat);
        end
      end else if (wbm_stb_o && act) begin
        len++;
      end else if (!wbm_stb_o && act) begin
        act = 0;
        if (cur.len != 0) chk("req_stb_len", len, cur.len);
      end
    end
  end

  // monitor: slow-side responses (32-bit)
  initial begin
    bit   act;
    int   len;
    rsp_t cur;
    act = 0; len = 0;
    forever begin
      @(negedge sys_clk);
      if ((wbs_ack_o || wbs_err_o) && !act) begin
        act = 1; len = 1;
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 1'b1, 1'b0);
          cur.len = 0;
        end else begin
          cur = exp_rsp.pop_front();
          $display("rsp: ack=%0b err=%0b dat=%h", wbs_ack_o, wbs_err_o, wbs_dat_o);
          chk("rsp_ack", wbs_ack_o, cur.ack);
          chk("rsp_err", wbs_err_o, cur.err);
          chk("rsp_dat", wbs_dat_o, cur.dat);
        end
      end else if ((wbs_ack_o || wbs_err_o) && act) begin
        len++;
        if (cur.len != 0 && wbs_dat_o !== cur.dat) chk("rsp_dat_stable", wbs_dat_o, cur.dat);
      end else if (act) begin
        act = 0;
        if (cur.len != 0) chk("rsp_len", len, cur.len);
      end
    end
  end

  // monitor: 64-bit instance
  initial begin
    bit     act;
    int     len;
    rsp64_t cur;
    act = 0; len = 0;
    forever begin
      @(negedge sys_clk);
      if (h_wbm_stb_o) begin
        if (exp_adr64.size() == 0) chk("req64_unexpected", 1'b1, 1'b0);
        else chk("req64_adr", h_wbm_adr_o, exp_adr64.pop_front());
      end
      if ((h_wbs_ack_o || h_wbs_err_o) && !act) begin
        act = 1; len = 1;
        if (exp_rsp64.size() == 0) begin
          chk("rsp64_unexpected", 1'b1, 1'b0);
          cur.len = 0;
        end else begin
          cur = exp_rsp64.pop_front();
          $display("rsp64: ack=%0b err=%0b dat=%h", h_wbs_ack_o, h_wbs_err_o, h_wbs_dat_o);
          chk("rsp64_err", h_wbs_err_o, 1'b0);
          chk("rsp64_dat", h_wbs_dat_o, cur.dat);
        end
      end else if ((h_wbs_ack_o || h_wbs_err_o) && act) begin
        len++;
      end else if (act) begin
        act = 0;
        if (cur.len != 0) chk("rsp64_len", len, cur.len);
      end
    end
  end

  // slow-side transfer: holds the request until the ce edge that sees the
  // response, then optionally keeps cyc/stb high for a back-to-back request
  task automatic slow_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, input int waits, input int mode,
                           input logic [31:0] sd, input logic [31:0] exp_dat, input bit keep);
    req_t r;
    rsp_t p;
    int   k;
    slv_waits = waits; slv_mode = mode; slv_data = sd;
    r.adr = a; r.dat = d; r.sel = s; r.we = w;
    r.len = (mode == M_SILENT) ? TO + 1 : waits + 1;
    p.ack = (mode == M_ACK); p.err = (mode != M_ACK); p.dat = exp_dat; p.len = 4;
    exp_req.push_back(r);
    exp_rsp.push_back(p);
    @(negedge sys_clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_adr = a; s_dat = d; s_sel = s; s_we = w;
    for (k = 0; k < 400; k++) begin
      @(negedge sys_clk);
      if (ce_i && (wbs_ack_o || wbs_err_o)) break;
    end
    chk("xfer_done", (k < 400), 1'b1);
    @(negedge sys_clk);
    if (!keep) begin
      s_cyc = 1'b0; s_stb = 1'b0;
    end
  endtask

  task automatic wait_stb(input string nm);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge sys_clk);
      if (wbm_stb_o) break;
    end
    chk(nm, (k < 100), 1'b1);
  endtask

  task automatic read64(input logic [31:0] a, input logic [63:0] d);
    rsp64_t p;
    int     k;
    slv_data64 = d;
    p.dat = d; p.len = 1;
    exp_rsp64.push_back(p);
    exp_adr64.push_back(a);
    @(negedge sys_clk);
    h_cyc = 1'b1; h_stb = 1'b1; h_adr = a; h_we = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge sys_clk);
      if (h_wbs_ack_o || h_wbs_err_o) break;
    end
    chk("xfer64_done", (k < 50), 1'b1);
    h_cyc = 1'b0; h_stb = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  initial begin
    req_t r;
    sys_rst = 1'b1;
    s_adr = '0; s_dat = '0; s_sel = '0; s_we = 1'b0; s_cyc = 1'b0; s_stb = 1'b0;
    h_adr = '0; h_dat = '0; h_sel = '0; h_we = 1'b0; h_cyc = 1'b0; h_stb = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_cyc", wbm_cyc_o, 1'b0);
    chk("rst_stb", wbm_stb_o, 1'b0);
    chk("rst_ack", wbs_ack_o, 1'b0);
    chk("rst_err", wbs_err_o, 1'b0);
    chk("rst_rdat", wbs_dat_o, 32'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_wdat", wbm_dat_o, 32'h0);
    chk("rst_sel", wbm_sel_o, 4'h0);
    chk("rst_we", wbm_we_o, 1'b0);
    chk("rst64_ack", h_wbs_ack_o, 1'b0);
    sys_rst = 1'b0;

    // read with 3 wait states
    slow_xfer(32'h100, 32'h0, 4'hF, 1'b0, 3, M_ACK, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    repeat (4) @(negedge sys_clk);
    // write, zero wait states: read data register unchanged
    slow_xfer(32'h104, 32'h55AA00FF, 4'b0101, 1'b1, 0, M_ACK, 32'h0, 32'hDEADBEEF, 1'b0);
    repeat (4) @(negedge sys_clk);
    // slave error
    slow_xfer(32'h108, 32'h0, 4'hF, 1'b0, 1, M_ERR, 32'h0, 32'hDEADBEEF, 1'b0);
    repeat (4) @(negedge sys_clk);
    // silent slave: timeout after TO+1 stb cycles
    slow_xfer(32'h10C, 32'h0, 4'hF, 1'b0, 0, M_SILENT, 32'h0, 32'hDEADBEEF, 1'b0);
    repeat (4) @(negedge sys_clk);
    // back-to-back with stb held across the ack
    slow_xfer(32'h110, 32'h0, 4'hF, 1'b0, 0, M_ACK, 32'h11111111, 32'h11111111, 1'b1);
    slow_xfer(32'h114, 32'h0, 4'hF, 1'b0, 1, M_ACK, 32'h22222222, 32'h22222222, 1'b0);
    repeat (4) @(negedge sys_clk);

    // abort while in REQ: full-rate cycle completes, no slow response
    slv_waits = 2; slv_mode = M_ACK; slv_data = 32'h99999999;
    r.adr = 32'h200; r.dat = '0; r.sel = 4'hF; r.we = 1'b0; r.len = 3;
    exp_req.push_back(r);
    @(negedge sys_clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_adr = 32'h200; s_sel = 4'hF; s_we = 1'b0;
    wait_stb("abort_stb_seen");
    s_cyc = 1'b0; s_stb = 1'b0;
    repeat (16) @(negedge sys_clk);

    // reset pulsed while in REQ
    slv_mode = M_SILENT;
    r.adr = 32'h300; r.len = 0;
    exp_req.push_back(r);
    @(negedge sys_clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_adr = 32'h300;
    wait_stb("rstmid_stb_seen");
    @(negedge sys_clk);
    sys_rst = 1'b1; s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge sys_clk);
    chk("rstmid_cyc", wbm_cyc_o, 1'b0);
    chk("rstmid_stb", wbm_stb_o, 1'b0);
    chk("rstmid_ack", wbs_ack_o, 1'b0);
    chk("rstmid_err", wbs_err_o, 1'b0);
    chk("rstmid_rdat", wbs_dat_o, 32'h0);
    chk("rstmid_adr", wbm_adr_o, 32'h0);
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
    slow_xfer(32'h120, 32'h0, 4'hF, 1'b0, 2, M_ACK, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);

    // 64-bit instance, ce tied high
    read64(32'h40, 64'h0123456789ABCDEF);
    read64(32'h48, 64'hFEDCBA9876543210);

    repeat (20) @(negedge sys_clk);
    chk("req_queue_empty", exp_req.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    chk("rsp64_queue_empty", exp_rsp64.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
